// File: rtl/cyl_to_rect.sv
// Iterative CORDIC converter from cylindrical (r, theta, z) to rectangular (x, y, z).
// It uses one micro-rotation per cycle, with valid/ready handshakes on both sides.
module cyl_to_rect #(
  parameter int unsigned ITER = 12,
  parameter int unsigned FRAC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] r,
  input  logic [7:0] theta,
  input  logic [7:0] z,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic [7:0] z_out
);

  localparam int unsigned W        = 11 + FRAC;
  localparam int unsigned Shift    = 16 - FRAC;
  localparam int unsigned RoundAdd = 1 << (Shift - 1);
  localparam logic signed [W-1:0] Half   = W'(1) << (FRAC - 1);
  localparam logic signed [W-1:0] PosMax = W'(255);
  localparam logic signed [W-1:0] NegMax = W'(-255);

  typedef enum logic [1:0] {StIdle, StRot, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic signed [W-1:0] xr_q, xr_d, yr_q, yr_d;
  logic signed [15:0]  ang_q, ang_d;
  logic [3:0]          iter_q, iter_d;
  logic [1:0]          quad_q, quad_d;
  logic [7:0]          zl_q, zl_d;
  logic [8:0]          x_q, x_d, y_q, y_d;
  logic                ov_q, ov_d;
  logic signed [W-1:0] x_init, fx, fy;

  function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'sd8192;
      4'd1:    return 16'sd4836;
      4'd2:    return 16'sd2555;
      4'd3:    return 16'sd1297;
      4'd4:    return 16'sd651;
      4'd5:    return 16'sd326;
      4'd6:    return 16'sd163;
      4'd7:    return 16'sd81;
      4'd8:    return 16'sd41;
      4'd9:    return 16'sd20;
      4'd10:   return 16'sd10;
      4'd11:   return 16'sd5;
      default: return 16'sd0;
    endcase
  endfunction

  // Round half-up to an integer, then clamp to [-255, 255].
  function automatic logic [8:0] round_sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] rnd;
    rnd = (v + Half) >>> FRAC;
    if (rnd > PosMax) begin
      return 9'd255;
    end else if (rnd < NegMax) begin
      return 9'h101;
    end
    return rnd[8:0];
  endfunction

  // Gain-compensated radius: round(r * 39797/65536 * 2^FRAC).
  assign x_init = W'((32'(r) * 32'd39797 + RoundAdd) >> Shift);

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    ang_d   = ang_q;
    iter_d  = iter_q;
    quad_d  = quad_q;
    zl_d    = zl_q;
    x_d     = x_q;
    y_d     = y_q;
    ov_d    = ov_q;
    fx      = xr_q;
    fy      = yr_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          quad_d  = theta[7:6];
          zl_d    = z;
          xr_d    = x_init;
          yr_d    = '0;
          ang_d   = {theta[5:0], 8'b0};
          iter_d  = '0;
          state_d = StRot;
        end
      end
      StRot: begin
        if (!ang_q[15]) begin
          xr_d  = xr_q - (yr_q >>> iter_q);
          yr_d  = yr_q + (xr_q >>> iter_q);
          ang_d = ang_q - atan_lut(iter_q);
        end else begin
          xr_d  = xr_q + (yr_q >>> iter_q);
          yr_d  = yr_q - (xr_q >>> iter_q);
          ang_d = ang_q + atan_lut(iter_q);
        end
        if (iter_q == 4'(ITER - 1)) begin
          state_d = StFix;
        end else begin
          iter_d = iter_q + 4'd1;
        end
      end
      StFix: begin
        case (quad_q)
          2'd0: begin fx = xr_q;  fy = yr_q;  end
          2'd1: begin fx = -yr_q; fy = xr_q;  end
          2'd2: begin fx = -xr_q; fy = -yr_q; end
          default: begin fx = yr_q; fy = -xr_q; end
        endcase
        x_d     = round_sat(fx);
        y_d     = round_sat(fy);
        ov_d    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      xr_q    <= '0;
      yr_q    <= '0;
      ang_q   <= '0;
      iter_q  <= '0;
      quad_q  <= '0;
      zl_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      ang_q   <= ang_d;
      iter_q  <= iter_d;
      quad_q  <= quad_d;
      zl_q    <= zl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = ov_q;
  assign x         = x_q;
  assign y         = y_q;
  assign z_out     = zl_q;

endmodule

// File: tb/tb_cyl_to_rect.sv
// Self-checking bench for cyl_to_rect: directed cases plus a randomized sweep
// compared against a floating-point polar-to-rectangular model.
module tb_cyl_to_rect;

  localparam real Pi  = 3.14159265358979;
  localparam int  Lat = 13;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] r, theta, z, z_out;
  logic [8:0] x, y;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cyl_to_rect #(.ITER(12), .FRAC(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r         (r),
    .theta     (theta),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .y         (y),
    .z_out     (z_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input real exp);
    real err;
    err = $itor(obs) - exp;
    tests++;
    assert ((err <= 1.0 && err >= -1.0) === 1'b1) else begin
      fails++;
      $error("FAIL %s: got %0d, want %f (+/-1)", tag, obs, exp);
    end
  endtask

  // Accept one request and wait (bounded) for the result; lat = -1 on timeout.
  task automatic send(input int rr, input int tt, input int zz, output int lat);
    chk_eq("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    r        = 8'(rr);
    theta    = 8'(tt);
    z        = 8'(zz);
    tick();
    in_valid = 1'b0;
    r        = 8'($urandom_range(0, 255));
    theta    = 8'($urandom_range(0, 255));
    z        = 8'($urandom_range(0, 255));
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic expect_result(input string tag, input int rr, input int tt, input int zz,
                               input int lat);
    real ang;
    int  xs, ys;
    ang = 2.0 * Pi * $itor(tt) / 256.0;
    xs  = int'($signed(x));
    ys  = int'($signed(y));
    chk_eq({tag, "_latency"}, lat, Lat);
    chk_near({tag, "_x"}, xs, $itor(rr) * $cos(ang));
    chk_near({tag, "_y"}, ys, $itor(rr) * $sin(ang));
    chk_eq({tag, "_xrange"}, int'(xs >= -255 && xs <= 255), 1);
    chk_eq({tag, "_yrange"}, int'(ys >= -255 && ys <= 255), 1);
    chk_eq({tag, "_z"}, int'(z_out), zz);
  endtask

  task automatic drain(input int stall);
    for (int n = 0; n < stall; n++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_eq("drain_out_valid", int'(out_valid), 0);
    chk_eq("drain_in_ready", int'(in_ready), 1);
  endtask

  task automatic run_one(input string tag, input int rr, input int tt, input int zz,
                         input int stall);
    int lat;
    send(rr, tt, zz, lat);
    expect_result(tag, rr, tt, zz, lat);
    drain(stall);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    r         = '0;
    theta     = '0;
    z         = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_eq("rst_out_valid", int'(out_valid), 0);
    chk_eq("rst_in_ready", int'(in_ready), 1);
    chk_eq("rst_x", int'(x), 0);
    chk_eq("rst_y", int'(y), 0);
    chk_eq("rst_z", int'(z_out), 0);

    // First result, then confirm it stays held after the handshake.
    send(100, 0, 7, lat);
    expect_result("t0", 100, 0, 7, lat);
    drain(0);
    chk_near("held_x", int'($signed(x)), 100.0);
    chk_eq("held_z", int'(z_out), 7);

    run_one("t90", 100, 64, 1, 1);
    run_one("t180", 200, 128, 2, 0);
    run_one("t45", 255, 32, 3, 2);
    run_one("t315", 255, 224, 4, 0);

    // r=0 with a stalled consumer and ignored input pulses.
    send(0, 77, 55, lat);
    expect_result("r0", 0, 77, 55, lat);
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      r        = 8'($urandom_range(1, 255));
      theta    = 8'($urandom_range(0, 255));
      z        = 8'($urandom_range(0, 255));
      tick();
      chk_eq("stall_out_valid", int'(out_valid), 1);
      chk_eq("stall_in_ready", int'(in_ready), 0);
      chk_eq("stall_x", int'(x), 0);
      chk_eq("stall_y", int'(y), 0);
      chk_eq("stall_z", int'(z_out), 55);
    end
    in_valid = 1'b0;
    drain(0);

    // Reset in the middle of the rotation phase.
    in_valid = 1'b1;
    r        = 8'd200;
    theta    = 8'd40;
    z        = 8'd9;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("midrst_out_valid", int'(out_valid), 0);
    chk_eq("midrst_in_ready", int'(in_ready), 1);
    chk_eq("midrst_x", int'(x), 0);
    chk_eq("midrst_y", int'(y), 0);
    chk_eq("midrst_z", int'(z_out), 0);
    for (int n = 0; n < 20; n++) tick();
    chk_eq("midrst_no_result", int'(out_valid), 0);
    run_one("t270", 50, 192, 11, 0);

    // Full-radius angle sweep, then random (r, theta, z) with random output stalls.
    for (int t = 0; t < 256; t += 8) run_one("sweep", 255, t, t, 0);
    for (int k = 0; k < 1500; k++) begin
      run_one("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
